// File: rtl/vec_pkg.sv
// Shared definitions for the vector issue controller and vec_exec.
// Holds the controller FSM state encoding, the default vector width,
// the vsew element-width encodings and the funct6 opcodes that both
// sides agree on.
package vec_pkg;

  localparam int VLEN_DEF = 256;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_ISSUE   = 3'd3,
    S_WAIT    = 3'd4,
    S_WB      = 3'd5
  } state_e;

  // vsew element-width encodings
  localparam logic [2:0] E8  = 3'b000;
  localparam logic [2:0] E16 = 3'b001;
  localparam logic [2:0] E32 = 3'b010;
  localparam logic [2:0] E64 = 3'b011;

  // funct6 opcodes understood by vec_exec
  localparam logic [5:0] F6_VADD = 6'b000000;
  localparam logic [5:0] F6_VSUB = 6'b000010;
  localparam logic [5:0] F6_VAND = 6'b001001;
  localparam logic [5:0] F6_VOR  = 6'b001010;
  localparam logic [5:0] F6_VXOR = 6'b001011;

endpackage

// File: rtl/vec_issue_ctrl.sv
// Single-outstanding issue controller for the vector execution unit.
// Accepts one decoded instruction (valid/ready), reads vs2/vs1 from the
// VRF, issues to vec_exec with a one-cycle new_instr pulse, waits for
// vec_op_done (bounded by TIMEOUT_CYCLES) and writes the result to vd.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   instr_*                    instruction handshake and decoded fields
//   vrf_rd_addr_a/b, _data_a/b VRF read ports (data 1 cycle after addr)
//   new_instr, vsew, funct6,
//   operand_a/b                issue interface to vec_exec
//   vec_exec_out, vec_op_done  completion interface from vec_exec
//   vrf_wr_en/addr/data        VRF write port
//   busy, timeout_err          status (timeout_err sticky until reset)
module vec_issue_ctrl
  import vec_pkg::*;
#(
  parameter int VLEN           = VLEN_DEF,
  parameter int VREG_AW        = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [5:0]         instr_funct6,
  input  logic [2:0]         instr_vsew,
  input  logic [VREG_AW-1:0] instr_vs1,
  input  logic [VREG_AW-1:0] instr_vs2,
  input  logic [VREG_AW-1:0] instr_vd,
  output logic [VREG_AW-1:0] vrf_rd_addr_a,
  output logic [VREG_AW-1:0] vrf_rd_addr_b,
  input  logic [VLEN-1:0]    vrf_rd_data_a,
  input  logic [VLEN-1:0]    vrf_rd_data_b,
  output logic               new_instr,
  output logic [2:0]         vsew,
  output logic [5:0]         funct6,
  output logic [VLEN-1:0]    operand_a,
  output logic [VLEN-1:0]    operand_b,
  input  logic [VLEN-1:0]    vec_exec_out,
  input  logic               vec_op_done,
  output logic               vrf_wr_en,
  output logic [VREG_AW-1:0] vrf_wr_addr,
  output logic [VLEN-1:0]    vrf_wr_data,
  output logic               busy,
  output logic               timeout_err
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [VREG_AW-1:0] vd_q, vd_d;
  logic [VREG_AW-1:0] rd_addr_a_q, rd_addr_a_d, rd_addr_b_q, rd_addr_b_d;
  logic               new_instr_q, new_instr_d;
  logic [2:0]         vsew_q, vsew_d;
  logic [5:0]         funct6_q, funct6_d;
  logic [VLEN-1:0]    op_a_q, op_a_d, op_b_q, op_b_d;
  logic               wr_en_q, wr_en_d;
  logic [VREG_AW-1:0] wr_addr_q, wr_addr_d;
  logic [VLEN-1:0]    wr_data_q, wr_data_d;
  logic               tmo_q, tmo_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vd_d        = vd_q;
    rd_addr_a_d = rd_addr_a_q;
    rd_addr_b_d = rd_addr_b_q;
    new_instr_d = 1'b0;
    vsew_d      = vsew_q;
    funct6_d    = funct6_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    tmo_d       = tmo_q;
    unique case (state_q)
      S_IDLE: if (instr_valid) begin
        // Read addresses are registered at accept so they are on the
        // VRF port during READ; data then lands in CAPTURE.
        rd_addr_a_d = instr_vs2;
        rd_addr_b_d = instr_vs1;
        vd_d        = instr_vd;
        funct6_d    = instr_funct6;
        vsew_d      = instr_vsew;
        state_d     = S_READ;
      end
      S_READ:    state_d = S_CAPTURE;
      S_CAPTURE: begin
        op_a_d      = vrf_rd_data_a;
        op_b_d      = vrf_rd_data_b;
        new_instr_d = 1'b1;          // registered: high during ISSUE only
        state_d     = S_ISSUE;
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (vec_op_done) begin
          wr_data_d = vec_exec_out;
          wr_addr_d = vd_q;
          wr_en_d   = 1'b1;          // registered: high during WB only
          state_d   = S_WB;
        end else if (cnt_q == CNT_LAST) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      vd_q        <= '0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      new_instr_q <= 1'b0;
      vsew_q      <= '0;
      funct6_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vd_q        <= vd_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      new_instr_q <= new_instr_d;
      vsew_q      <= vsew_d;
      funct6_q    <= funct6_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      tmo_q       <= tmo_d;
    end
  end

  assign instr_ready   = (state_q == S_IDLE) & ~reset;
  assign busy          = (state_q != S_IDLE);
  assign vrf_rd_addr_a = rd_addr_a_q;
  assign vrf_rd_addr_b = rd_addr_b_q;
  assign new_instr     = new_instr_q;
  assign vsew          = vsew_q;
  assign funct6        = funct6_q;
  assign operand_a     = op_a_q;
  assign operand_b     = op_b_q;
  assign vrf_wr_en     = wr_en_q;
  assign vrf_wr_addr   = wr_addr_q;
  assign vrf_wr_data   = wr_data_q;
  assign timeout_err   = tmo_q;

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Randomized self-checking bench for vec_issue_ctrl. The reference model
// tracks each accepted instruction as a transaction with a relative cycle
// number (accept edge ends cycle 0) and derives every expected output from
// the documented timeline: read addresses in cycle 1, VRF data in cycle 2,
// issue pulse in cycle 3, done in cycle 3+lat, writeback in 4+lat, or a
// timeout after TIMEOUT_CYCLES waiting cycles.
module tb_vec_issue_ctrl;
  import vec_pkg::*;

  localparam int VLEN = 256;
  localparam int AW   = 5;
  localparam int T    = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            instr_valid, instr_ready;
  logic [5:0]      instr_funct6;
  logic [2:0]      instr_vsew;
  logic [AW-1:0]   instr_vs1, instr_vs2, instr_vd;
  logic [AW-1:0]   vrf_rd_addr_a, vrf_rd_addr_b;
  logic [VLEN-1:0] vrf_rd_data_a, vrf_rd_data_b;
  logic            new_instr;
  logic [2:0]      vsew;
  logic [5:0]      funct6;
  logic [VLEN-1:0] operand_a, operand_b, vec_exec_out;
  logic            vec_op_done, vrf_wr_en, busy, timeout_err;
  logic [AW-1:0]   vrf_wr_addr;
  logic [VLEN-1:0] vrf_wr_data;

  always #5 clk = ~clk;

  vec_issue_ctrl #(.VLEN(VLEN), .VREG_AW(AW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_funct6(instr_funct6), .instr_vsew(instr_vsew),
    .instr_vs1(instr_vs1), .instr_vs2(instr_vs2), .instr_vd(instr_vd),
    .vrf_rd_addr_a(vrf_rd_addr_a), .vrf_rd_addr_b(vrf_rd_addr_b),
    .vrf_rd_data_a(vrf_rd_data_a), .vrf_rd_data_b(vrf_rd_data_b),
    .new_instr(new_instr), .vsew(vsew), .funct6(funct6),
    .operand_a(operand_a), .operand_b(operand_b),
    .vec_exec_out(vec_exec_out), .vec_op_done(vec_op_done),
    .vrf_wr_en(vrf_wr_en), .vrf_wr_addr(vrf_wr_addr), .vrf_wr_data(vrf_wr_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  int errs = 0, nchk = 0, nwb = 0;

  task automatic chk(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Model state
  logic [VLEN-1:0] vrf [32];
  bit              active, dcase, tmo_m, inj_done, spur_en;
  int              rel, lat, lat_next, end_rel;
  logic [5:0]      m_f6;
  logic [2:0]      m_sew;
  logic [AW-1:0]   m_vs1, m_vs2, m_vd;
  logic [VLEN-1:0] m_a, m_b, m_res;

  function automatic logic [VLEN-1:0] rnd_vec();
    logic [VLEN-1:0] v;
    for (int i = 0; i < VLEN/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Stand-in for vec_exec's arithmetic; any deterministic function works.
  function automatic logic [VLEN-1:0] exec_fn(input logic [VLEN-1:0] a, b, input logic [5:0] f6);
    return a + b + VLEN'(f6);
  endfunction

  task automatic tick();
    bit acc, rst_b, real_d, spur_ok, wb_e;
    acc   = instr_valid && !reset && !active;
    rst_b = reset;
    if (acc) begin
      m_f6 = instr_funct6; m_sew = instr_vsew;
      m_vs1 = instr_vs1; m_vs2 = instr_vs2; m_vd = instr_vd;
      m_a = vrf[instr_vs2]; m_b = vrf[instr_vs1];
      m_res = exec_fn(m_a, m_b, m_f6);
      lat = lat_next;
      dcase = (lat >= 1) && (lat <= T);
      end_rel = dcase ? 5 + lat : 4 + T;
      active = 1; rel = 0;
    end
    @(posedge clk); #1;
    if (rst_b) begin active = 0; tmo_m = 0; end
    else if (active) rel++;
    if (active && !dcase && rel == 4 + T) tmo_m = 1;
    if (active && rel >= end_rel) active = 0;
    wb_e = active && dcase && rel == 4 + lat;

    chk("instr_ready", instr_ready, !active && !reset);
    chk("busy", busy, active);
    chk("new_instr", new_instr, active && rel == 3);
    chk("vrf_wr_en", vrf_wr_en, wb_e);
    chk("timeout_err", timeout_err, tmo_m);
    if (wb_e) begin
      chk("wr_addr", vrf_wr_addr, m_vd);
      chk("wr_data", vrf_wr_data, m_res);
      vrf[vrf_wr_addr] = vrf_wr_data;
      nwb++;
    end
    if (active && rel == 1) begin
      chk("rd_addr_a", vrf_rd_addr_a, m_vs2);
      chk("rd_addr_b", vrf_rd_addr_b, m_vs1);
    end
    if (active && rel >= 3 && rel <= (dcase ? 3 + lat : 3 + T)) begin
      chk("operand_a", operand_a, m_a);
      chk("operand_b", operand_b, m_b);
      chk("vsew", vsew, m_sew);
      chk("funct6", funct6, m_f6);
    end

    // Inputs for the current cycle: VRF data is only meaningful in cycle 2.
    if (active && rel == 2) begin
      vrf_rd_data_a = m_a; vrf_rd_data_b = m_b;
    end else begin
      vrf_rd_data_a = rnd_vec(); vrf_rd_data_b = rnd_vec();
    end
    real_d  = active && dcase && rel == 3 + lat;
    spur_ok = !active || rel <= 3 || (dcase && rel == 4 + lat);
    vec_op_done  = real_d || inj_done || (spur_en && spur_ok && $urandom_range(0, 3) == 0);
    inj_done     = 0;
    vec_exec_out = real_d ? m_res : rnd_vec();
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    reset = 0;
    chk("rst_operand_a", operand_a, '0);
    chk("rst_operand_b", operand_b, '0);
    chk("rst_vsew", vsew, '0);
    chk("rst_funct6", funct6, '0);
    chk("rst_rd_addr_a", vrf_rd_addr_a, '0);
    chk("rst_rd_addr_b", vrf_rd_addr_b, '0);
    chk("rst_wr_addr", vrf_wr_addr, '0);
    chk("rst_wr_data", vrf_wr_data, '0);
  endtask

  task automatic offer(input logic [5:0] f6, input logic [2:0] sew,
                       input logic [AW-1:0] vs1, vs2, vd, input int l);
    int n;
    instr_funct6 = f6; instr_vsew = sew;
    instr_vs1 = vs1; instr_vs2 = vs2; instr_vd = vd;
    instr_valid = 1; lat_next = l;
    n = 0;
    do begin tick(); n++; end while (!(active && rel == 1) && n < 50);
    chk("accept_seen", active && rel == 1, 1'b1);
  endtask

  task automatic run_one(input logic [5:0] f6, input logic [2:0] sew,
                         input logic [AW-1:0] vs1, vs2, vd, input int l, input bit hold);
    int n;
    offer(f6, sew, vs1, vs2, vd, l);
    if (hold) begin
      instr_funct6 = 6'($urandom); instr_vsew = 3'($urandom);
      instr_vs1 = 5'($urandom); instr_vs2 = 5'($urandom); instr_vd = 5'($urandom);
    end else instr_valid = 0;
    n = 0;
    while (active && n < 60) begin tick(); n++; end
    chk("op_finished", active, 1'b0);
  endtask

  initial begin
    int wb0;
    reset = 1; instr_valid = 0; instr_funct6 = '0; instr_vsew = '0;
    instr_vs1 = '0; instr_vs2 = '0; instr_vd = '0;
    vrf_rd_data_a = '0; vrf_rd_data_b = '0; vec_exec_out = '0; vec_op_done = 0;
    active = 0; tmo_m = 0; inj_done = 0; spur_en = 0; lat_next = 1; rel = 0;
    for (int i = 0; i < 32; i++) vrf[i] = rnd_vec();
    do_reset();
    do_reset();

    // Basic op
    vrf[2] = {32{8'h01}}; vrf[1] = {32{8'h02}};
    run_one(F6_VADD, E8, 5'd1, 5'd2, 5'd3, 3, 0);
    chk("basic_v3", vrf[3], {32{8'h03}});
    chk("basic_wb_count", nwb, 1);

    // Back-to-back with valid held high, latency 1, vd overlaps sources
    run_one(F6_VXOR, E16, 5'd3, 5'd4, 5'd4, 1, 1);
    run_one(F6_VSUB, E32, 5'd4, 5'd4, 5'd5, 1, 1);
    instr_valid = 0;
    chk("b2b_wb_count", nwb, 3);

    // Timeout: no done ever
    wb0 = nwb;
    run_one(F6_VAND, E64, 5'd6, 5'd7, 5'd8, 0, 0);
    chk("timeout_no_wb", nwb, wb0);
    chk("timeout_flag", timeout_err, 1'b1);
    run_one(F6_VOR, E8, 5'd9, 5'd10, 5'd11, 2, 0);

    // Reset two cycles after new_instr, then a late done pulse
    wb0 = nwb;
    offer(F6_VADD, E8, 5'd12, 5'd13, 5'd14, 8);
    instr_valid = 0;
    while (active && rel < 5) tick();
    do_reset();
    inj_done = 1;
    repeat (12) tick();
    chk("rst_mid_no_wb", nwb, wb0);

    // Randomized phase with spurious done pulses outside WAIT
    spur_en = 1;
    for (int k = 0; k < 40; k++) begin
      int l;
      bit hold;
      l = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, T + 2));
      hold = $urandom_range(0, 1) == 1;
      run_one(6'($urandom), 3'($urandom_range(0, 3)), 5'($urandom), 5'($urandom),
              5'($urandom), l, hold);
      if (!hold) repeat ($urandom_range(0, 2)) tick();
    end
    instr_valid = 0;
    spur_en = 0;
    repeat (3) tick();
    do_reset();
    chk("final_tmo_cleared", timeout_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule

// File: doc/vec_issue_ctrl.md
Name: vec_issue_ctrl

Overview:
Issue-side controller for the vector execution unit; it is the initiator that drives vec_exec's new_instr/vsew/funct6/operand_a/operand_b and consumes vec_exec_out/vec_op_done. It accepts one decoded vector instruction at a time from the pipeline via valid/ready, reads two source registers from the vector register file (VRF), issues to vec_exec, waits for completion and writes the result back to the VRF. It is strictly single-outstanding.

Parameters:
VLEN, 256, vector register width in bits
VREG_AW, 5, VRF address width
TIMEOUT_CYCLES, 64, max WAIT cycles before abort

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
instr_valid  in  1  pipeline offers instruction
instr_ready  out  1  controller can accept
instr_funct6  in  6  operation select
instr_vsew  in  3  element width encoding
instr_vs1  in  VREG_AW  source register 1
instr_vs2  in  VREG_AW  source register 2
instr_vd  in  VREG_AW  destination register
vrf_rd_addr_a  out  VREG_AW  VRF read port A address (vs2)
vrf_rd_addr_b  out  VREG_AW  VRF read port B address (vs1)
vrf_rd_data_a  in  VLEN  port A data, valid 1 cycle after address
vrf_rd_data_b  in  VLEN  port B data, valid 1 cycle after address
new_instr  out  1  one-cycle start pulse to vec_exec
vsew  out  3  to vec_exec
funct6  out  6  to vec_exec
operand_a  out  VLEN  to vec_exec (vs2 data)
operand_b  out  VLEN  to vec_exec (vs1 data)
vec_exec_out  in  VLEN  result from vec_exec
vec_op_done  in  1  completion pulse from vec_exec
vrf_wr_en  out  1  VRF write strobe
vrf_wr_addr  out  VREG_AW  write address (vd)
vrf_wr_data  out  VLEN  write data
busy  out  1  state != IDLE
timeout_err  out  1  sticky abort flag

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all registered outputs 0 (new_instr, vsew, funct6, operand_a/b, vrf_rd_addr_a/b, vrf_wr_*, timeout_err, wait counter). instr_ready = (state==IDLE) & ~reset.
- FSM: IDLE -> READ -> CAPTURE -> ISSUE -> WAIT -> WB -> IDLE.
- IDLE: instr_ready=1; on instr_valid&instr_ready latch funct6/vsew/vs1/vs2/vd and go to READ (accept = cycle 0).
- READ (cycle 1): vrf_rd_addr_a=vs2, vrf_rd_addr_b=vs1.
- CAPTURE (cycle 2): register vrf_rd_data_a -> operand_a and vrf_rd_data_b -> operand_b; drive latched vsew/funct6.
- ISSUE (cycle 3): new_instr=1 for exactly this cycle; clear wait counter.
- WAIT: operand_a/b, vsew and funct6 are held stable until state leaves WAIT. Each cycle, on vec_op_done: register vec_exec_out -> vrf_wr_data, vd -> vrf_wr_addr, go to WB. Otherwise increment the counter; if counter == TIMEOUT_CYCLES-1 without done: set timeout_err, go to IDLE, no writeback.
- WB: vrf_wr_en=1 for exactly one cycle, then IDLE.
- Minimum latency: accept at cycle 0, done at cycle 4 -> vrf_wr_en at cycle 5 -> instr_ready at cycle 6.
- vec_op_done is sampled only in WAIT. It is ignored in IDLE, READ, CAPTURE, ISSUE and WB; vec_exec guarantees at least 1 cycle of latency.
- timeout_err is sticky and cleared only by reset; the controller keeps operating after an abort.
- Reset mid-operation: abort immediately, no vrf_wr_en, no new_instr, later done pulses ignored.
- vd equal to vs1 or vs2 is legal: reads complete before the write.
- instr_* fields are don't-care when not accepted.

Decomposition:
- Shared package vec_pkg: FSM state enum (IDLE, READ, CAPTURE, ISSUE, WAIT, WB), VLEN default, vsew encodings (E8=000, E16=001, E32=010, E64=011), funct6 opcode constants shared with vec_exec.
- No sub-module: the FSM plus one counter fits in a single module.

Test Plan:
- Basic op: v2=32x8'h01, v1=32x8'h02; issue funct6=6'b000000, vsew=000, vs2=2, vs1=1, vd=3; model raises done 3 cycles after new_instr returning 32x8'h03 -> one new_instr pulse at cycle 3 with operand_a=v2 and operand_b=v1; one vrf_wr_en with addr 3, data 32x8'h03.
- Back-to-back: instr_valid held high with two instructions, model latency 1 -> instr_ready low from cycle 1 through WB; second accept exactly at cycle 6; two writebacks in order.
- Timeout: TIMEOUT_CYCLES=16, model never asserts done -> timeout_err rises after the 16th WAIT cycle; no vrf_wr_en; instr_ready=1 next cycle; timeout_err stays 1 until reset.
- Reset mid-WAIT: assert reset 2 cycles after new_instr, then done arrives -> next cycle all outputs 0, state IDLE, no vrf_wr_en ever.
- Spurious done: vec_op_done pulsed in IDLE and in the ISSUE cycle -> no writeback, no state change; the real done in WAIT writes once.
- Operand stability: change VRF read data every cycle during WAIT -> operand_a/b, vsew, funct6 unchanged from CAPTURE until WB.
